// File: rtl/ysyx_040750_axi_pkg.sv
// Shared AXI constants and FSM state types for the 1:N router.
package ysyx_040750_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_XFER,
        W_RESP
    } w_state_e;

endpackage

// File: rtl/ysyx_040750_addr_decoder.sv
// Base/mask region decoder: one-hot slave select, lowest index wins, miss when no region hits.
module ysyx_040750_addr_decoder #(
    parameter int                 NSLV     = 2,
    parameter int                 AW       = 32,
    parameter logic [NSLV*AW-1:0] SLV_BASE = {32'h0000_0000, 32'h0200_0000},
    parameter logic [NSLV*AW-1:0] SLV_MASK = {32'h0000_0000, 32'hFFFF_0000}
) (
    input  logic [AW-1:0]   addr,
    output logic [NSLV-1:0] sel,
    output logic            miss
);

    logic found;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (!found && ((addr & SLV_MASK[i*AW+:AW]) == SLV_BASE[i*AW+:AW])) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
        miss = !found;
    end

endmodule

// File: rtl/ysyx_040750_axi_router.sv
// 1-master to NSLV-slave AXI4 router; independent read/write FSMs, one outstanding each,
// unmapped addresses answered internally with DECERR.
module ysyx_040750_axi_router
    import ysyx_040750_axi_pkg::*;
#(
    parameter int                 NSLV     = 2,
    parameter int                 AW       = 32,
    parameter int                 DW       = 64,
    parameter logic [NSLV*AW-1:0] SLV_BASE = {32'h0000_0000, 32'h0200_0000},
    parameter logic [NSLV*AW-1:0] SLV_MASK = {32'h0000_0000, 32'hFFFF_0000}
) (
    input  logic                   I_clk,
    input  logic                   I_rst_n,
    input  logic [AW-1:0]          I_m_araddr,
    input  logic [7:0]             I_m_arlen,
    input  logic [2:0]             I_m_arsize,
    input  logic [1:0]             I_m_arburst,
    input  logic                   I_m_arvalid,
    output logic                   O_m_arready,
    output logic [DW-1:0]          O_m_rdata,
    output logic [1:0]             O_m_rresp,
    output logic                   O_m_rlast,
    output logic                   O_m_rvalid,
    input  logic                   I_m_rready,
    input  logic [AW-1:0]          I_m_awaddr,
    input  logic [7:0]             I_m_awlen,
    input  logic [2:0]             I_m_awsize,
    input  logic [1:0]             I_m_awburst,
    input  logic                   I_m_awvalid,
    output logic                   O_m_awready,
    input  logic [DW-1:0]          I_m_wdata,
    input  logic [DW/8-1:0]        I_m_wstrb,
    input  logic                   I_m_wlast,
    input  logic                   I_m_wvalid,
    output logic                   O_m_wready,
    output logic [1:0]             O_m_bresp,
    output logic                   O_m_bvalid,
    input  logic                   I_m_bready,
    output logic [NSLV*AW-1:0]     O_s_araddr,
    output logic [NSLV*8-1:0]      O_s_arlen,
    output logic [NSLV*3-1:0]      O_s_arsize,
    output logic [NSLV*2-1:0]      O_s_arburst,
    output logic [NSLV*AW-1:0]     O_s_awaddr,
    output logic [NSLV*8-1:0]      O_s_awlen,
    output logic [NSLV*3-1:0]      O_s_awsize,
    output logic [NSLV*2-1:0]      O_s_awburst,
    output logic [NSLV-1:0]        O_s_arvalid,
    output logic [NSLV-1:0]        O_s_awvalid,
    output logic [NSLV-1:0]        O_s_wvalid,
    output logic [NSLV-1:0]        O_s_rready,
    output logic [NSLV-1:0]        O_s_bready,
    input  logic [NSLV-1:0]        I_s_arready,
    input  logic [NSLV-1:0]        I_s_awready,
    input  logic [NSLV-1:0]        I_s_wready,
    input  logic [NSLV-1:0]        I_s_rvalid,
    input  logic [NSLV-1:0]        I_s_rlast,
    input  logic [NSLV-1:0]        I_s_bvalid,
    input  logic [NSLV*DW-1:0]     I_s_rdata,
    input  logic [NSLV*2-1:0]      I_s_rresp,
    input  logic [NSLV*2-1:0]      I_s_bresp,
    output logic [NSLV*DW-1:0]     O_s_wdata,
    output logic [NSLV*DW/8-1:0]   O_s_wstrb,
    output logic [NSLV-1:0]        O_s_wlast
);

    r_state_e        r_state, r_next;
    w_state_e        w_state, w_next;

    logic [NSLV-1:0] ar_sel, aw_sel;
    logic            ar_miss, aw_miss;

    logic [AW-1:0]   ar_addr_q, aw_addr_q;
    logic [7:0]      ar_len_q, aw_len_q;
    logic [2:0]      ar_size_q, aw_size_q;
    logic [1:0]      ar_burst_q, aw_burst_q;
    logic [NSLV-1:0] ar_sel_q, aw_sel_q;
    logic            ar_err_q, aw_err_q;
    logic [7:0]      r_cnt;
    logic            aw_done, w_done;
    logic            aw_hs, wl_hs;

    ysyx_040750_addr_decoder #(
        .NSLV(NSLV), .AW(AW), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
    ) u_ar_dec (
        .addr(I_m_araddr), .sel(ar_sel), .miss(ar_miss)
    );

    ysyx_040750_addr_decoder #(
        .NSLV(NSLV), .AW(AW), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
    ) u_aw_dec (
        .addr(I_m_awaddr), .sel(aw_sel), .miss(aw_miss)
    );

    // Payloads are broadcast; only the handshakes are steered by the select.
    assign O_s_araddr  = {NSLV{ar_addr_q}};
    assign O_s_arlen   = {NSLV{ar_len_q}};
    assign O_s_arsize  = {NSLV{ar_size_q}};
    assign O_s_arburst = {NSLV{ar_burst_q}};
    assign O_s_awaddr  = {NSLV{aw_addr_q}};
    assign O_s_awlen   = {NSLV{aw_len_q}};
    assign O_s_awsize  = {NSLV{aw_size_q}};
    assign O_s_awburst = {NSLV{aw_burst_q}};
    assign O_s_wdata   = {NSLV{I_m_wdata}};
    assign O_s_wstrb   = {NSLV{I_m_wstrb}};
    assign O_s_wlast   = {NSLV{I_m_wlast}};

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state    <= R_IDLE;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            ar_sel_q   <= '0;
            ar_err_q   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && I_m_arvalid) begin
                ar_addr_q  <= I_m_araddr;
                ar_len_q   <= I_m_arlen;
                ar_size_q  <= I_m_arsize;
                ar_burst_q <= I_m_arburst;
                ar_sel_q   <= ar_sel;
                ar_err_q   <= ar_miss;
                r_cnt      <= I_m_arlen;
            end else if (r_state == R_DATA && ar_err_q && I_m_rready && r_cnt != '0) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        r_next      = r_state;
        O_m_arready = 1'b0;
        O_s_arvalid = '0;
        O_s_rready  = '0;
        O_m_rvalid  = 1'b0;
        O_m_rdata   = '0;
        O_m_rresp   = RESP_OKAY;
        O_m_rlast   = 1'b0;
        case (r_state)
            R_IDLE: begin
                O_m_arready = 1'b1;
                if (I_m_arvalid) r_next = ar_miss ? R_DATA : R_ADDR;
            end
            R_ADDR: begin
                O_s_arvalid = ar_sel_q;
                if (|(I_s_arready & ar_sel_q)) r_next = R_DATA;
            end
            R_DATA: begin
                if (ar_err_q) begin
                    O_m_rvalid = 1'b1;
                    O_m_rresp  = RESP_DECERR;
                    O_m_rlast  = (r_cnt == '0);
                end else begin
                    O_s_rready = ar_sel_q & {NSLV{I_m_rready}};
                    for (int unsigned i = 0; i < NSLV; i++) begin
                        if (ar_sel_q[i]) begin
                            O_m_rvalid = I_s_rvalid[i];
                            O_m_rdata  = I_s_rdata[i*DW+:DW];
                            O_m_rresp  = I_s_rresp[i*2+:2];
                            O_m_rlast  = I_s_rlast[i];
                        end
                    end
                end
                if (O_m_rvalid && I_m_rready && O_m_rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            w_state    <= W_IDLE;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            aw_sel_q   <= '0;
            aw_err_q   <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            w_state <= w_next;
            if (w_state == W_IDLE && I_m_awvalid) begin
                aw_addr_q  <= I_m_awaddr;
                aw_len_q   <= I_m_awlen;
                aw_size_q  <= I_m_awsize;
                aw_burst_q <= I_m_awburst;
                aw_sel_q   <= aw_sel;
                aw_err_q   <= aw_miss;
                aw_done    <= aw_miss;
                w_done     <= 1'b0;
            end else if (w_state == W_XFER) begin
                if (aw_hs) aw_done <= 1'b1;
                if (wl_hs) w_done  <= 1'b1;
            end
        end
    end

    // AW and W are offered together so slaves that wait for wvalid before awready still progress.
    always_comb begin
        w_next      = w_state;
        O_m_awready = 1'b0;
        O_s_awvalid = '0;
        O_s_wvalid  = '0;
        O_m_wready  = 1'b0;
        O_s_bready  = '0;
        O_m_bvalid  = 1'b0;
        O_m_bresp   = RESP_OKAY;
        aw_hs       = 1'b0;
        wl_hs       = 1'b0;
        case (w_state)
            W_IDLE: begin
                O_m_awready = 1'b1;
                if (I_m_awvalid) w_next = W_XFER;
            end
            W_XFER: begin
                if (!aw_done) begin
                    O_s_awvalid = aw_sel_q;
                    aw_hs       = |(aw_sel_q & I_s_awready);
                end
                if (!w_done) begin
                    if (aw_err_q) begin
                        O_m_wready = 1'b1;
                    end else begin
                        O_s_wvalid = aw_sel_q & {NSLV{I_m_wvalid}};
                        O_m_wready = |(aw_sel_q & I_s_wready);
                    end
                    wl_hs = I_m_wvalid && O_m_wready && I_m_wlast;
                end
                if ((aw_done || aw_hs) && (w_done || wl_hs)) w_next = W_RESP;
            end
            W_RESP: begin
                if (aw_err_q) begin
                    O_m_bvalid = 1'b1;
                    O_m_bresp  = RESP_DECERR;
                end else begin
                    O_s_bready = aw_sel_q & {NSLV{I_m_bready}};
                    for (int unsigned i = 0; i < NSLV; i++) begin
                        if (aw_sel_q[i]) begin
                            O_m_bvalid = I_s_bvalid[i];
                            O_m_bresp  = I_s_bresp[i*2+:2];
                        end
                    end
                end
                if (O_m_bvalid && I_m_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_040750_axi_router.sv
// Randomized self-checking bench for the AXI router with three behavioural slaves.
module tb_ysyx_040750_axi_router;

    localparam int N = 3;

    logic          I_clk = 1'b0;
    logic          I_rst_n;
    logic [31:0]   I_m_araddr, I_m_awaddr;
    logic [7:0]    I_m_arlen, I_m_awlen;
    logic [2:0]    I_m_arsize, I_m_awsize;
    logic [1:0]    I_m_arburst, I_m_awburst;
    logic          I_m_arvalid, I_m_rready, I_m_awvalid, I_m_wlast, I_m_wvalid, I_m_bready;
    logic [63:0]   I_m_wdata;
    logic [7:0]    I_m_wstrb;
    logic          O_m_arready, O_m_rlast, O_m_rvalid, O_m_awready, O_m_wready, O_m_bvalid;
    logic [63:0]   O_m_rdata;
    logic [1:0]    O_m_rresp, O_m_bresp;
    logic [N*32-1:0] O_s_araddr, O_s_awaddr;
    logic [N*8-1:0]  O_s_arlen, O_s_awlen, O_s_wstrb;
    logic [N*3-1:0]  O_s_arsize, O_s_awsize;
    logic [N*2-1:0]  O_s_arburst, O_s_awburst, I_s_rresp, I_s_bresp;
    logic [N-1:0]    O_s_arvalid, O_s_awvalid, O_s_wvalid, O_s_rready, O_s_bready, O_s_wlast;
    logic [N-1:0]    I_s_arready, I_s_awready, I_s_wready, I_s_rvalid, I_s_rlast, I_s_bvalid;
    logic [N*64-1:0] I_s_rdata, O_s_wdata;

    ysyx_040750_axi_router #(
        .NSLV(3), .AW(32), .DW(64),
        .SLV_BASE({32'h1000_0000, 32'h8000_0000, 32'h0200_0000}),
        .SLV_MASK({32'hFFFF_F000, 32'hF000_0000, 32'hFFFF_0000})
    ) dut (
        .I_clk(I_clk), .I_rst_n(I_rst_n),
        .I_m_araddr(I_m_araddr), .I_m_arlen(I_m_arlen), .I_m_arsize(I_m_arsize),
        .I_m_arburst(I_m_arburst), .I_m_arvalid(I_m_arvalid), .O_m_arready(O_m_arready),
        .O_m_rdata(O_m_rdata), .O_m_rresp(O_m_rresp), .O_m_rlast(O_m_rlast),
        .O_m_rvalid(O_m_rvalid), .I_m_rready(I_m_rready),
        .I_m_awaddr(I_m_awaddr), .I_m_awlen(I_m_awlen), .I_m_awsize(I_m_awsize),
        .I_m_awburst(I_m_awburst), .I_m_awvalid(I_m_awvalid), .O_m_awready(O_m_awready),
        .I_m_wdata(I_m_wdata), .I_m_wstrb(I_m_wstrb), .I_m_wlast(I_m_wlast),
        .I_m_wvalid(I_m_wvalid), .O_m_wready(O_m_wready),
        .O_m_bresp(O_m_bresp), .O_m_bvalid(O_m_bvalid), .I_m_bready(I_m_bready),
        .O_s_araddr(O_s_araddr), .O_s_arlen(O_s_arlen), .O_s_arsize(O_s_arsize),
        .O_s_arburst(O_s_arburst), .O_s_awaddr(O_s_awaddr), .O_s_awlen(O_s_awlen),
        .O_s_awsize(O_s_awsize), .O_s_awburst(O_s_awburst),
        .O_s_arvalid(O_s_arvalid), .O_s_awvalid(O_s_awvalid), .O_s_wvalid(O_s_wvalid),
        .O_s_rready(O_s_rready), .O_s_bready(O_s_bready),
        .I_s_arready(I_s_arready), .I_s_awready(I_s_awready), .I_s_wready(I_s_wready),
        .I_s_rvalid(I_s_rvalid), .I_s_rlast(I_s_rlast), .I_s_bvalid(I_s_bvalid),
        .I_s_rdata(I_s_rdata), .I_s_rresp(I_s_rresp), .I_s_bresp(I_s_bresp),
        .O_s_wdata(O_s_wdata), .O_s_wstrb(O_s_wstrb), .O_s_wlast(O_s_wlast)
    );

    always #5 I_clk = ~I_clk;

    int ncmp = 0;
    int nfail = 0;
    int stray_rd = 0;
    int stray_wr = 0;
    int exp_rd_slv = -1;
    int exp_wr_slv = -1;
    logic [2:0] aw_wait = '0;

    logic [31:0] reg_base [N] = '{32'h0200_0000, 32'h8000_0000, 32'h1000_0000};
    logic [31:0] reg_mask [N] = '{32'hFFFF_0000, 32'hF000_0000, 32'hFFFF_F000};

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < N; i++)
            if ((a & reg_mask[i]) == reg_base[i]) return i;
        return -1;
    endfunction

    function automatic logic [63:0] rd_pat(input int s, input logic [31:0] a, input logic [7:0] b);
        return {a ^ (32'h1111_1111 * 32'(s + 1)), 24'hC0FFEE, b};
    endfunction

    function automatic logic [1:0] slv_resp(input int s);
        return (s == 1) ? 2'b01 : 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural slaves: one outstanding read and one outstanding write each.
    logic        sr_busy [N];
    logic [31:0] sr_addr [N];
    logic [7:0]  sr_len [N], sr_beat [N];
    logic        sw_aw [N], sw_w [N], sw_seen [N], sw_first [N];
    logic [31:0] sw_addr [N], rec_addr [N];
    logic [7:0]  sw_len [N], rec_len [N], sw_sx [N], rec_sx [N];
    logic [63:0] sw_xor [N], rec_xor [N];
    int          sw_cnt [N], rec_cnt [N];
    logic        rec_first [N];

    always_comb begin
        I_s_arready = '0; I_s_rvalid = '0; I_s_rlast = '0; I_s_rdata = '0; I_s_rresp = '0;
        I_s_awready = '0; I_s_wready = '0; I_s_bvalid = '0; I_s_bresp = '0;
        for (int i = 0; i < N; i++) begin
            I_s_arready[i]      = !sr_busy[i];
            I_s_rvalid[i]       = sr_busy[i];
            I_s_rlast[i]        = sr_busy[i] && (sr_beat[i] == sr_len[i]);
            I_s_rdata[i*64+:64] = rd_pat(i, sr_addr[i], sr_beat[i]);
            I_s_rresp[i*2+:2]   = slv_resp(i);
            I_s_awready[i]      = !sw_aw[i] && (!aw_wait[i] || sw_seen[i]);
            I_s_wready[i]       = !sw_w[i];
            I_s_bvalid[i]       = sw_aw[i] && sw_w[i];
            I_s_bresp[i*2+:2]   = slv_resp(i);
        end
    end

    always @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int i = 0; i < N; i++) begin
                sr_busy[i] <= 1'b0; sr_addr[i] <= '0; sr_len[i] <= '0; sr_beat[i] <= '0;
                sw_aw[i] <= 1'b0; sw_w[i] <= 1'b0; sw_seen[i] <= 1'b0; sw_first[i] <= 1'b0;
                sw_addr[i] <= '0; sw_len[i] <= '0; sw_xor[i] <= '0; sw_sx[i] <= '0; sw_cnt[i] <= 0;
                rec_addr[i] <= '0; rec_len[i] <= '0; rec_xor[i] <= '0; rec_sx[i] <= '0;
                rec_cnt[i] <= 0; rec_first[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (O_s_arvalid[i] && I_s_arready[i]) begin
                    sr_busy[i] <= 1'b1;
                    sr_addr[i] <= O_s_araddr[i*32+:32];
                    sr_len[i]  <= O_s_arlen[i*8+:8];
                    sr_beat[i] <= '0;
                end else if (sr_busy[i] && O_s_rready[i]) begin
                    if (sr_beat[i] == sr_len[i]) sr_busy[i] <= 1'b0;
                    else sr_beat[i] <= sr_beat[i] + 8'd1;
                end
                if (O_s_awvalid[i] && I_s_awready[i]) begin
                    sw_aw[i]   <= 1'b1;
                    sw_addr[i] <= O_s_awaddr[i*32+:32];
                    sw_len[i]  <= O_s_awlen[i*8+:8];
                end
                if (O_s_wvalid[i] && I_s_wready[i]) begin
                    sw_seen[i] <= 1'b1;
                    sw_xor[i]  <= sw_xor[i] ^ O_s_wdata[i*64+:64];
                    sw_sx[i]   <= sw_sx[i] ^ O_s_wstrb[i*8+:8];
                    sw_cnt[i]  <= sw_cnt[i] + 1;
                    if (!sw_aw[i]) sw_first[i] <= 1'b1;
                    if (O_s_wlast[i]) sw_w[i] <= 1'b1;
                end
                if (I_s_bvalid[i] && O_s_bready[i]) begin
                    rec_addr[i] <= sw_addr[i]; rec_len[i] <= sw_len[i]; rec_xor[i] <= sw_xor[i];
                    rec_sx[i] <= sw_sx[i]; rec_cnt[i] <= sw_cnt[i]; rec_first[i] <= sw_first[i];
                    sw_aw[i] <= 1'b0; sw_w[i] <= 1'b0; sw_seen[i] <= 1'b0; sw_first[i] <= 1'b0;
                    sw_xor[i] <= '0; sw_sx[i] <= '0; sw_cnt[i] <= 0;
                end
            end
        end
    end

    always @(negedge I_clk) begin
        if (I_rst_n) begin
            for (int j = 0; j < N; j++) begin
                if ((O_s_arvalid[j] || O_s_rready[j]) && j != exp_rd_slv) stray_rd++;
                if ((O_s_awvalid[j] || O_s_wvalid[j] || O_s_bready[j]) && j != exp_wr_slv) stray_wr++;
            end
        end
    end

    // Tasks start and end one time unit after a rising edge.
    task automatic do_read(input logic [31:0] a, input logic [7:0] len, input int mode);
        int s, b, t, lim;
        bit ok;
        s = ref_decode(a);
        exp_rd_slv = s;
        lim = (int'(len) + 1) * 4 + 40;
        I_m_araddr = a; I_m_arlen = len; I_m_arsize = 3'd3; I_m_arburst = 2'b01; I_m_arvalid = 1'b1;
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge I_clk);
            if (O_m_arready) begin ok = 1; break; end
            @(posedge I_clk); #1;
        end
        chk("ar_accept", 64'(ok), 1);
        @(posedge I_clk); #1;
        I_m_arvalid = 1'b0;
        @(negedge I_clk);
        chk("ar_fwd", 64'(O_s_arvalid), (s >= 0) ? 64'(1 << s) : 64'd0);
        chk("arready_busy", 64'(O_m_arready), 0);
        @(posedge I_clk); #1;
        b = 0; t = 0;
        while (b <= int'(len) && t < lim) begin
            I_m_rready = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 2 == 1) : 1'($urandom);
            @(negedge I_clk);
            t++;
            if (O_m_rvalid && I_m_rready) begin
                chk("rdata", O_m_rdata, (s >= 0) ? rd_pat(s, a, 8'(b)) : 64'd0);
                chk("rresp", 64'(O_m_rresp), (s >= 0) ? 64'(slv_resp(s)) : 64'd3);
                chk("rlast", 64'(O_m_rlast), 64'(b == int'(len)));
                chk("arready_low", 64'(O_m_arready), 0);
                b++;
            end
            @(posedge I_clk); #1;
        end
        I_m_rready = 1'b0;
        chk("r_beats", 64'(b), 64'(int'(len) + 1));
        @(negedge I_clk);
        chk("arready_idle", 64'(O_m_arready), 1);
        chk("rd_stray", 64'(stray_rd), 0);
        exp_rd_slv = -1;
        @(posedge I_clk); #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] len);
        int s, b, t, lim;
        bit ok, got;
        logic [63:0] xr;
        logic [7:0] sx;
        s = ref_decode(a);
        exp_wr_slv = s;
        lim = (int'(len) + 1) * 6 + 40;
        I_m_awaddr = a; I_m_awlen = len; I_m_awsize = 3'd3; I_m_awburst = 2'b01; I_m_awvalid = 1'b1;
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge I_clk);
            if (O_m_awready) begin ok = 1; break; end
            @(posedge I_clk); #1;
        end
        chk("aw_accept", 64'(ok), 1);
        @(posedge I_clk); #1;
        I_m_awvalid = 1'b0;
        xr = '0; sx = '0; b = 0; t = 0;
        while (b <= int'(len) && t < lim) begin
            I_m_wvalid = ($urandom % 4) != 0;
            I_m_wdata  = {$urandom, $urandom};
            I_m_wstrb  = 8'($urandom);
            I_m_wlast  = (b == int'(len));
            @(negedge I_clk);
            t++;
            if (s < 0) chk("err_wready", 64'(O_m_wready), 1);
            if (I_m_wvalid && O_m_wready) begin
                xr ^= I_m_wdata; sx ^= I_m_wstrb; b++;
            end
            @(posedge I_clk); #1;
        end
        I_m_wvalid = 1'b0; I_m_wlast = 1'b0;
        chk("w_beats", 64'(b), 64'(int'(len) + 1));
        got = 0; t = 0;
        while (!got && t < lim) begin
            I_m_bready = ($urandom % 3) != 0;
            @(negedge I_clk);
            t++;
            if (O_m_bvalid && I_m_bready) begin
                got = 1;
                chk("bresp", 64'(O_m_bresp), (s >= 0) ? 64'(slv_resp(s)) : 64'd3);
                chk("awready_low", 64'(O_m_awready), 0);
            end
            @(posedge I_clk); #1;
        end
        I_m_bready = 1'b0;
        chk("b_done", 64'(got), 1);
        @(negedge I_clk);
        chk("awready_idle", 64'(O_m_awready), 1);
        if (s >= 0) begin
            chk("s_awaddr", 64'(rec_addr[s]), 64'(a));
            chk("s_awlen", 64'(rec_len[s]), 64'(len));
            chk("s_wxor", rec_xor[s], xr);
            chk("s_wstrb", 64'(rec_sx[s]), 64'(sx));
            chk("s_wcnt", 64'(rec_cnt[s]), 64'(int'(len) + 1));
        end
        chk("wr_stray", 64'(stray_wr), 0);
        exp_wr_slv = -1;
        @(posedge I_clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [7:0] len;
        I_rst_n = 1'b0;
        I_m_araddr = '0; I_m_arlen = '0; I_m_arsize = '0; I_m_arburst = '0; I_m_arvalid = 1'b0;
        I_m_rready = 1'b0; I_m_awaddr = '0; I_m_awlen = '0; I_m_awsize = '0; I_m_awburst = '0;
        I_m_awvalid = 1'b0; I_m_wdata = '0; I_m_wstrb = '0; I_m_wlast = 1'b0; I_m_wvalid = 1'b0;
        I_m_bready = 1'b0;
        repeat (3) @(posedge I_clk);
        #1;
        chk("rst_arready", 64'(O_m_arready), 1);
        chk("rst_awready", 64'(O_m_awready), 1);
        chk("rst_rvalid", 64'(O_m_rvalid), 0);
        chk("rst_bvalid", 64'(O_m_bvalid), 0);
        chk("rst_wready", 64'(O_m_wready), 0);
        chk("rst_s_valids", 64'({O_s_arvalid, O_s_awvalid, O_s_wvalid}), 0);
        chk("rst_s_readys", 64'({O_s_rready, O_s_bready}), 0);
        @(negedge I_clk);
        I_rst_n = 1'b1;
        @(posedge I_clk); #1;

        do_read(32'h0200_BFF8, 8'd0, 0);
        do_read(32'h8000_0040, 8'd7, 1);
        do_read(32'h4000_0000, 8'd3, 2);
        aw_wait = 3'b100;
        do_write(32'h1000_0010, 8'd0);
        chk("w_before_aw", 64'(rec_first[2]), 1);
        aw_wait = '0;
        do_write(32'h4000_0000, 8'd1);
        do_read(32'h4000_0000, 8'd255, 0);
        fork
            do_read(32'h0200_0100, 8'd3, 2);
            do_write(32'h8000_1000, 8'd3);
        join

        repeat (60) begin
            case ($urandom % 5)
                0: a = 32'h0200_0000 | ($urandom & 32'h0000_FFFF);
                1: a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
                2: a = 32'h1000_0000 | ($urandom & 32'h0000_0FFF);
                default: a = $urandom;
            endcase
            len = ($urandom % 8 == 0) ? 8'($urandom % 64) : 8'($urandom % 8);
            aw_wait = 3'($urandom);
            case ($urandom % 3)
                0: do_read(a, len, int'($urandom % 3));
                1: do_write(a, len);
                default: fork
                    do_read(a, len, int'($urandom % 3));
                    do_write(32'h8000_0000 | ($urandom & 32'h0FFF_FFFF), 8'($urandom % 4));
                join
            endcase
        end

        // Reset while a read burst is streaming and a write waits on its slave.
        aw_wait = 3'b010; exp_rd_slv = 1; exp_wr_slv = 1;
        chk("pre_rst_arready", 64'(O_m_arready), 1);
        I_m_araddr = 32'h8000_0000; I_m_arlen = 8'd7; I_m_arvalid = 1'b1; I_m_rready = 1'b1;
        I_m_awaddr = 32'h8000_2000; I_m_awlen = 8'd0; I_m_awvalid = 1'b1;
        @(posedge I_clk); #1;
        I_m_arvalid = 1'b0; I_m_awvalid = 1'b0;
        repeat (3) @(posedge I_clk);
        #3;
        chk("mid_rvalid", 64'(O_m_rvalid), 1);
        chk("mid_awvalid", 64'(O_s_awvalid), 64'b010);
        I_rst_n = 1'b0;
        #1;
        chk("rst_rvalid2", 64'(O_m_rvalid), 0);
        chk("rst_s_valids2", 64'({O_s_arvalid, O_s_awvalid, O_s_wvalid}), 0);
        chk("rst_s_readys2", 64'({O_s_rready, O_s_bready}), 0);
        chk("rst_mwb", 64'({O_m_wready, O_m_bvalid}), 0);
        I_m_rready = 1'b0;
        aw_wait = '0; exp_rd_slv = -1; exp_wr_slv = -1;
        @(negedge I_clk);
        I_rst_n = 1'b1;
        @(negedge I_clk);
        chk("post_rst_arready", 64'(O_m_arready), 1);
        chk("post_rst_awready", 64'(O_m_awready), 1);
        @(posedge I_clk); #1;
        do_read(32'h1000_0008, 8'd2, 0);
        do_write(32'h0200_0040, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/ysyx_040750_axi_router.md
# ysyx_040750_axi_router

Parametrised 1-master-to-NSLV-slave AXI4 router that replaces the fixed two-way slave crossbar between the cache/LSU master port and the system slaves (CLINT, main bus, future MMIO). Address decode uses per-slave base/mask regions. Read and write run as independent state machines, each with one outstanding transaction. Unmapped addresses go to an internal error responder that returns DECERR with correct burst length.

## Interface
Parameters:
- NSLV, 2, number of slave ports
- AW, 32, address width
- DW, 64, data width (wstrb width DW/8)
- SLV_BASE, {32'h0000_0000, 32'h0200_0000}, NSLV×AW flattened base addresses (slave i at bits [i*AW+:AW])
- SLV_MASK, {32'h0000_0000, 32'hFFFF_0000}, NSLV×AW flattened masks; slave 1 defaults to catch-all

Ports (flattened slave buses are NSLV×width, slave i at [i*w+:w]):
- I_clk  in  1  clock
- I_rst_n  in  1  asynchronous active-low reset
- I_m_araddr/arlen/arsize/arburst  in  AW/8/3/2  master read address payload
- I_m_arvalid / O_m_arready  in/out  1  master AR handshake
- O_m_rdata/rresp/rlast  out  DW/2/1  master read data
- O_m_rvalid / I_m_rready  out/in  1  master R handshake
- I_m_awaddr/awlen/awsize/awburst  in  AW/8/3/2  master write address payload
- I_m_awvalid / O_m_awready  in/out  1  master AW handshake
- I_m_wdata/wstrb/wlast  in  DW/DW8/1  master write data
- I_m_wvalid / O_m_wready  in/out  1  master W handshake
- O_m_bresp  out  2  write response
- O_m_bvalid / I_m_bready  out/in  1  master B handshake
- O_s_araddr/arlen/arsize/arburst, O_s_awaddr/awlen/awsize/awburst  out  NSLV×field  payloads per slave
- O_s_arvalid, O_s_awvalid, O_s_wvalid, O_s_rready, O_s_bready  out  NSLV  per-slave valid/ready
- I_s_arready, I_s_awready, I_s_wready, I_s_rvalid, I_s_rlast, I_s_bvalid  in  NSLV  per-slave handshakes
- I_s_rdata/rresp, I_s_bresp  in  NSLV×DW/2, NSLV×2  slave responses
- O_s_wdata/wstrb/wlast  out  NSLV×DW/DW8/1  write data per slave

## Operation
- Decode: hit_i = (addr & MASK_i) == BASE_i; lowest index wins on multiple hits; no hit selects the error responder (sel = ERR).
- Read FSM: R_IDLE → R_ADDR → R_DATA → R_IDLE.
  - R_IDLE: O_m_arready=1; on arvalid, register payload and decoded sel. Go to R_ADDR, or R_DATA if sel=ERR with beat counter = arlen.
  - R_ADDR: O_s_arvalid[sel]=1 with registered payload; on I_s_arready[sel] go to R_DATA.
  - R_DATA: route slave sel's R channel to the master (rready, rvalid, rdata, rresp, rlast). On rvalid&rready&rlast go to R_IDLE.
  - Error: rvalid=1, rdata=0, rresp=2'b11. Counter decrements per handshake; rlast when counter==0.
- Write FSM: W_IDLE → W_XFER → W_RESP → W_IDLE.
  - W_XFER forwards AW and W concurrently, so a slave that waits for wvalid before awready cannot deadlock. Flags aw_done and w_done set on the AW handshake and the wlast handshake.
  - When both flags are set, go to W_RESP. W_RESP routes B; on bvalid&bready go to W_IDLE.
  - Error: AW completes immediately, wready=1 for all beats, then bvalid with bresp=2'b11.
- Payloads are broadcast to all slaves; only valid/ready signals are gated by sel. Unselected slaves see valid=0 and ready=0.
- Read and write are fully independent. Both may target the same slave at once.

## Timing
- Reset (async assert): FSMs go to IDLE; flags, counters and payload registers clear. All valids, rready, bready and wready are 0. O_m_arready and O_m_awready read 1 (IDLE).
- An in-flight transaction at reset is dropped. Slaves share the same reset.
- Latency: master AR/AW handshake to slave valid is 1 cycle. R/W/B data paths are combinational (0 cycles).
- O_m_arready is low from the cycle after acceptance until the cycle after the rlast handshake. O_m_awready is low until the cycle after the B handshake.
- Back-to-back: a new AR is accepted in the first R_IDLE cycle after completion, giving minimum 1 idle cycle between transactions.
- Valid is never dropped before its handshake.
- Error responder accepts arlen 0..255, giving 1..256 beats.

## Structure
- Package ysyx_040750_axi_pkg holds:
  - RESP_OKAY=2'b00, RESP_DECERR=2'b11
  - burst encodings
  - R and W state enums
- Sub-module ysyx_040750_addr_decoder: combinational, parametrised by NSLV/AW/SLV_BASE/SLV_MASK, outputs one-hot sel plus miss. Instantiated once for AR and once for AW.

## Test plan
All scenarios use NSLV=3: s0 base 0x0200_0000 mask 0xFFFF_0000; s1 base 0x8000_0000 mask 0xF000_0000; s2 base 0x1000_0000 mask 0xFFFF_F000.
- Read 0x0200_BFF8, arlen=0, s0 returns 0x1234 → O_s_arvalid=3'b001 one cycle after accept, O_m_rdata=0x1234 with rlast=1, O_m_arready=0 until after rlast.
- Read 0x8000_0040, arlen=7, I_m_rready toggling every cycle → 8 beats in order, rlast only on beat 8, s0/s2 valid/ready stay 0.
- Read 0x4000_0000 (unmapped), arlen=3 → 4 beats rdata=0, rresp=2'b11, rlast on beat 4, no O_s_arvalid.
- Write 0x1000_0010 to s2, which holds awready=0 until wvalid is seen → W beat forwarded first, AW completes, bresp=OKAY, no deadlock.
- Write 0x4000_0000 (unmapped), awlen=1 → 2 W beats accepted with wready=1, then bvalid with bresp=2'b11.
- Concurrent read of s0 and write to s1 → both complete independently. Then I_rst_n=0 mid 8-beat burst → all valids go 0 immediately, and arready/awready=1 after release.
